serial_acc_unit: RTL and testbench
==================================

Name: serial_acc_unit

Overview:
- Parametrised bit-serial accumulator: the next generation of the team's 8-bit serial shift accumulator.
- Adds true LSB-first serial add/subtract with a carry flop, load and hold/stream modes, and signed overflow detection with optional saturation.
- Adds a start/busy/done handshake and a stall qualifier.
- Sits between the serial multiplier datapath and the result serialiser; o_data_out streams the pre-pass accumulator while a pass runs.

Parameters:
- WIDTH, 8, accumulator width in bits (>=2); one pass = WIDTH enabled bit cycles.
- SATURATE, 0, 1 = clamp the result to signed max/min on overflow at pass end; 0 = wrap.

Ports:
- i_clk  input  1  clock, rising edge.
- i_rst  input  1  synchronous active-high reset.
- i_clr  input  1  synchronous clear of accumulator, carry and ovf; aborts a running pass.
- i_start  input  1  begin a pass (sampled in IDLE only).
- i_mode  input  2  latched at start: 00 LOAD, 01 ADD, 10 SUB (acc - operand), 11 HOLD (rotate, acc unchanged).
- i_bit_en  input  1  advance one bit this cycle; low = stall.
- i_data_in  input  1  serial operand bit, LSB first, two's complement.
- o_data_out  output  1  acc[0]: the current pre-pass accumulator bit being shifted out.
- o_acc  output  WIDTH  parallel accumulator value.
- o_busy  output  1  high in RUN.
- o_done  output  1  one-cycle pulse, cycle after the final bit.
- o_ovf  output  1  signed overflow of the last ADD/SUB pass; sticky until next start/clr/rst.

Behaviour:
- Reset (i_rst=1 at an edge): acc=0, carry=0, count=0, state=IDLE, o_busy=0, o_done=0, o_ovf=0. o_data_out=0 follows from acc.
- Priority: i_rst > i_clr > i_start/bit processing.
- i_clr: acc, carry, count, o_ovf <= 0; state <= IDLE; no o_done. A simultaneous i_start is ignored.
- FSM IDLE -> RUN:
  - Trigger: i_start=1 and i_clr=0.
  - Latch mode; count <= 0; carry <= 1 if SUB, else 0; o_ovf <= 0.
  - The bit on i_data_in in the start cycle is not consumed.
- RUN, each cycle with i_bit_en=1:
  - a = acc[0]; b = i_data_in, inverted for SUB.
  - new bit: LOAD = b; ADD/SUB = a^b^carry; HOLD = a.
  - acc <= {new, acc[WIDTH-1:1]}.
  - carry <= majority(a,b,carry) for ADD/SUB; unchanged otherwise.
  - count++.
- RUN with i_bit_en=0: no state change; o_data_out stays stable.
- Final bit (count==WIDTH-1 with i_bit_en):
  - ADD/SUB: ovf = carry_in_to_msb XOR carry_out; o_ovf <= ovf.
  - If SATURATE=1 and ovf: acc <= 0111..1 when the MSB operands are both 0, else 1000..0.
  - state <= IDLE; o_done <= 1 for the next cycle only.
  - LOAD/HOLD never set o_ovf.
- i_start while RUN is ignored. A new start is accepted the same cycle o_done is high (back-to-back passes).
- o_busy = (state==RUN).
- All outputs are registered except o_data_out and o_busy, which decode from flops.
- Latency: pass result is visible on o_acc in the o_done cycle. A pass takes WIDTH enabled cycles plus 1 (the start cycle).
- Counter width is clog2(WIDTH); no wrap beyond WIDTH-1.

Test Plan (WIDTH=8 unless noted):
- Reset, then LOAD of serial 0x05 (LSB first), then ADD of 0x03 -> o_acc=0x08, o_ovf=0, o_done pulses once 9 cycles after each start.
- SUB with acc=0x03, operand 0x05 -> o_acc=0xFE, o_ovf=0. During the pass, o_data_out emits 1,1,0,0,0,0,0,0.
- ADD 0x70+0x20:
  - SATURATE=0 -> o_acc=0x90, o_ovf=1.
  - SATURATE=1 -> o_acc=0x7F, o_ovf=1.
  - Likewise 0x80+0xFF with SATURATE=1 -> 0x80, o_ovf=1.
- ADD 0x12+0x34 with i_bit_en low on alternating cycles -> o_acc=0x46, o_done 17 cycles after start, o_data_out constant across stalled cycles.
- HOLD with acc=0xA5 -> o_data_out streams 1,0,1,0,0,1,0,1 and o_acc=0xA5 at done. i_start asserted mid-pass is ignored.
- i_clr at bit 3 of an ADD -> next cycle o_acc=0, o_busy=0, no o_done. i_rst mid-pass behaves the same. i_clr and i_start in the same cycle -> stays IDLE.

Source files
------------

// File: rtl/serial_acc_unit.sv
// Bit-serial LSB-first accumulator with LOAD/ADD/SUB/HOLD passes, start/busy/done
// handshake, stall qualifier and signed overflow detection with optional saturation.
module serial_acc_unit #(
  parameter int unsigned WIDTH    = 8,
  parameter bit          SATURATE = 1'b0
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_clr,
  input  logic             i_start,
  input  logic [1:0]       i_mode,
  input  logic             i_bit_en,
  input  logic             i_data_in,
  output logic             o_data_out,
  output logic [WIDTH-1:0] o_acc,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_ovf
);

  localparam int unsigned   CW   = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic {S_IDLE, S_RUN} state_e;
  typedef enum logic [1:0] {
    M_LOAD = 2'b00,
    M_ADD  = 2'b01,
    M_SUB  = 2'b10,
    M_HOLD = 2'b11
  } mode_e;

  state_e           state_q, state_d;
  mode_e            mode_q, mode_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic             carry_q, carry_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             ovf_q, ovf_d;
  logic             done_q, done_d;

  logic             arith, a, b, cout, ovf_now, new_bit;
  logic [WIDTH-1:0] shifted, sat_val;

  // One full-adder slice; SUB is acc + ~operand + 1 with the +1 preloaded into carry.
  always_comb begin
    arith   = (mode_q == M_ADD) || (mode_q == M_SUB);
    a       = acc_q[0];
    b       = i_data_in ^ (mode_q == M_SUB);
    cout    = (a & b) | (a & carry_q) | (b & carry_q);
    ovf_now = arith & (carry_q ^ cout);
    case (mode_q)
      M_LOAD:  new_bit = b;
      M_HOLD:  new_bit = a;
      default: new_bit = a ^ b ^ carry_q;
    endcase
    shifted = {new_bit, acc_q[WIDTH-1:1]};
    sat_val = (!a && !b) ? {1'b0, {(WIDTH-1){1'b1}}} : {1'b1, {(WIDTH-1){1'b0}}};
  end

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    acc_d   = acc_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    done_d  = 1'b0;
    if (i_clr) begin
      state_d = S_IDLE;
      acc_d   = '0;
      carry_d = 1'b0;
      cnt_d   = '0;
      ovf_d   = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (i_start) begin
            state_d = S_RUN;
            mode_d  = mode_e'(i_mode);
            cnt_d   = '0;
            carry_d = (mode_e'(i_mode) == M_SUB);
            ovf_d   = 1'b0;
          end
        end
        default: begin
          if (i_bit_en) begin
            acc_d = shifted;
            if (arith) carry_d = cout;
            if (cnt_q == LAST) begin
              state_d = S_IDLE;
              done_d  = 1'b1;
              cnt_d   = '0;
              ovf_d   = ovf_now;
              if (SATURATE && ovf_now) acc_d = sat_val;
            end else begin
              cnt_d = cnt_q + CW'(1);
            end
          end
        end
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= S_IDLE;
      mode_q  <= M_LOAD;
      acc_q   <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      acc_q   <= acc_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
      done_q  <= done_d;
    end
  end

  assign o_data_out = acc_q[0];
  assign o_acc      = acc_q;
  assign o_busy     = (state_q == S_RUN);
  assign o_done     = done_q;
  assign o_ovf      = ovf_q;

endmodule

// File: tb/tb_serial_acc_unit.sv
// Scoreboard bench: each pass pushes expected {ovf, acc} for a wrapping and a
// saturating instance; a monitor pops and compares whenever o_done pulses.
module tb_serial_acc_unit;
  localparam int W = 8;

  logic clk = 1'b0;
  logic rst, clr, start, bit_en, din;
  logic [1:0] mode;
  logic dout0, busy0, done0, ovf0, dout1, busy1, done1, ovf1;
  logic [W-1:0] acc0, acc1;

  int errors = 0;
  int checks = 0;
  logic [8:0] q0[$];
  logic [8:0] q1[$];
  logic [8:0] e0_m, e1_m;
  logic [7:0] stream;

  always #5 clk = ~clk;

  serial_acc_unit #(.WIDTH(W), .SATURATE(1'b0)) u_dut0 (
    .i_clk(clk), .i_rst(rst), .i_clr(clr), .i_start(start), .i_mode(mode),
    .i_bit_en(bit_en), .i_data_in(din), .o_data_out(dout0), .o_acc(acc0),
    .o_busy(busy0), .o_done(done0), .o_ovf(ovf0));

  serial_acc_unit #(.WIDTH(W), .SATURATE(1'b1)) u_dut1 (
    .i_clk(clk), .i_rst(rst), .i_clr(clr), .i_start(start), .i_mode(mode),
    .i_bit_en(bit_en), .i_data_in(din), .o_data_out(dout1), .o_acc(acc1),
    .o_busy(busy1), .o_done(done1), .o_ovf(ovf1));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (done0 === 1'b1) begin
      if (q0.size() == 0) begin
        checks++; errors++;
        $display("FAIL dut0 done with empty scoreboard: acc=0x%0h", acc0);
      end else begin
        e0_m = q0.pop_front();
        chk("dut0 acc at done", {24'b0, acc0}, {24'b0, e0_m[7:0]});
        chk("dut0 ovf at done", {31'b0, ovf0}, {31'b0, e0_m[8]});
      end
    end
    if (done1 === 1'b1) begin
      if (q1.size() == 0) begin
        checks++; errors++;
        $display("FAIL dut1 done with empty scoreboard: acc=0x%0h", acc1);
      end else begin
        e1_m = q1.pop_front();
        chk("dut1 acc at done", {24'b0, acc1}, {24'b0, e1_m[7:0]});
        chk("dut1 ovf at done", {31'b0, ovf1}, {31'b0, e1_m[8]});
      end
    end
  end

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; clr = 1'b0; start = 1'b0; bit_en = 1'b0; din = 1'b0; mode = 2'b00;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Full pass; inputs change on negedges, outputs are sampled on negedges.
  task automatic run_pass(input logic [1:0] m, input logic [7:0] opnd, input bit stall,
                          input bit b2b, input int midstart,
                          input logic [7:0] e0, input bit o0,
                          input logic [7:0] e1, input bit o1,
                          output logic [7:0] strm);
    bit bad_stall = 1'b0;
    bit bad_busy  = 1'b0;
    logic sbit;
    if (!b2b) @(negedge clk);
    q0.push_back({o0, e0});
    q1.push_back({o1, e1});
    start = 1'b1; mode = m; bit_en = 1'b0; din = 1'b0;
    sbit = 1'b0;
    strm = '0;
    for (int i = 0; i < W; i++) begin
      if (stall) begin
        @(negedge clk);
        start = 1'b0; bit_en = 1'b0; din = ~opnd[i];
        sbit = dout0;
        if (busy0 !== 1'b1 || done0 !== 1'b0) bad_busy = 1'b1;
      end
      @(negedge clk);
      start = (i == midstart);
      mode = (i == midstart) ? 2'b00 : m;
      bit_en = 1'b1; din = opnd[i];
      strm[i] = dout0;
      if (stall && sbit !== dout0) bad_stall = 1'b1;
      if (busy0 !== 1'b1 || done0 !== 1'b0) bad_busy = 1'b1;
    end
    @(negedge clk);
    start = 1'b0; bit_en = 1'b0; din = 1'b0;
    chk("dut0 done on final cycle", {31'b0, done0}, 32'd1);
    chk("dut1 done on final cycle", {31'b0, done1}, 32'd1);
    chk("busy low at done", {31'b0, busy0}, 32'd0);
    chk("busy high and no early done during pass", {31'b0, bad_busy}, 32'd0);
    if (stall) chk("data_out stable across stalls", {31'b0, bad_stall}, 32'd0);
  endtask

  task automatic abort_pass(input logic [7:0] opnd, input int nbits, input bit use_rst);
    bit bad = 1'b0;
    @(negedge clk);
    start = 1'b1; mode = 2'b01; bit_en = 1'b0;
    for (int i = 0; i < nbits; i++) begin
      @(negedge clk);
      start = 1'b0; bit_en = 1'b1; din = opnd[i];
    end
    @(negedge clk);
    bit_en = 1'b1; din = opnd[nbits];
    if (use_rst) rst = 1'b1; else clr = 1'b1;
    @(negedge clk);
    rst = 1'b0; clr = 1'b0; bit_en = 1'b0; din = 1'b0;
    chk(use_rst ? "acc after rst abort" : "acc after clr abort", {24'b0, acc0}, 32'd0);
    chk("busy after abort", {31'b0, busy0}, 32'd0);
    chk("done after abort", {31'b0, done0}, 32'd0);
    chk("ovf after abort", {31'b0, ovf0}, 32'd0);
    repeat (12) begin
      @(negedge clk);
      if (done0 !== 1'b0 || busy0 !== 1'b0) bad = 1'b1;
    end
    chk("no done or busy after abort", {31'b0, bad}, 32'd0);
  endtask

  initial begin
    bit bad;
    do_reset();
    chk("reset acc", {24'b0, acc0}, 32'd0);
    chk("reset busy", {31'b0, busy0}, 32'd0);
    chk("reset done", {31'b0, done0}, 32'd0);
    chk("reset ovf", {31'b0, ovf0}, 32'd0);
    chk("reset data_out", {31'b0, dout0}, 32'd0);
    chk("reset acc sat", {24'b0, acc1}, 32'd0);

    run_pass(2'b00, 8'h05, 0, 0, -1, 8'h05, 0, 8'h05, 0, stream);
    run_pass(2'b01, 8'h03, 0, 0, -1, 8'h08, 0, 8'h08, 0, stream);

    run_pass(2'b00, 8'h03, 0, 0, -1, 8'h03, 0, 8'h03, 0, stream);
    run_pass(2'b10, 8'h05, 0, 0, -1, 8'hFE, 0, 8'hFE, 0, stream);
    chk("SUB data_out stream", {24'b0, stream}, 32'h03);

    run_pass(2'b00, 8'h70, 0, 0, -1, 8'h70, 0, 8'h70, 0, stream);
    run_pass(2'b01, 8'h20, 0, 0, -1, 8'h90, 1, 8'h7F, 1, stream);
    run_pass(2'b00, 8'h80, 0, 0, -1, 8'h80, 0, 8'h80, 0, stream);
    run_pass(2'b01, 8'hFF, 0, 0, -1, 8'h7F, 1, 8'h80, 1, stream);

    @(negedge clk); clr = 1'b1;
    @(negedge clk); clr = 1'b0;
    chk("idle clr acc", {24'b0, acc0}, 32'd0);
    chk("idle clr ovf", {31'b0, ovf0}, 32'd0);
    chk("idle clr ovf sat", {31'b0, ovf1}, 32'd0);

    run_pass(2'b00, 8'h12, 0, 0, -1, 8'h12, 0, 8'h12, 0, stream);
    run_pass(2'b01, 8'h34, 1, 0, -1, 8'h46, 0, 8'h46, 0, stream);
    chk("stalled ADD data_out stream", {24'b0, stream}, 32'h12);

    run_pass(2'b00, 8'hA5, 0, 0, -1, 8'hA5, 0, 8'hA5, 0, stream);
    run_pass(2'b11, 8'hFF, 0, 0, 4, 8'hA5, 0, 8'hA5, 0, stream);
    chk("HOLD data_out stream", {24'b0, stream}, 32'hA5);

    run_pass(2'b00, 8'h01, 0, 0, -1, 8'h01, 0, 8'h01, 0, stream);
    run_pass(2'b01, 8'h01, 0, 1, -1, 8'h02, 0, 8'h02, 0, stream);

    abort_pass(8'h05, 3, 0);
    run_pass(2'b00, 8'h3C, 0, 0, -1, 8'h3C, 0, 8'h3C, 0, stream);
    abort_pass(8'h05, 3, 1);

    bad = 1'b0;
    @(negedge clk); clr = 1'b1; start = 1'b1; mode = 2'b00;
    @(negedge clk); clr = 1'b0; start = 1'b0; bit_en = 1'b1; din = 1'b1;
    chk("clr+start stays idle", {31'b0, busy0}, 32'd0);
    repeat (9) begin
      @(negedge clk);
      if (busy0 !== 1'b0 || done0 !== 1'b0) bad = 1'b1;
    end
    bit_en = 1'b0; din = 1'b0;
    chk("clr+start no pass", {31'b0, bad}, 32'd0);
    chk("clr+start acc", {24'b0, acc0}, 32'd0);

    repeat (3) @(negedge clk);
    chk("scoreboard drained dut0", q0.size(), 32'd0);
    chk("scoreboard drained dut1", q1.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
